// File: rtl/ros2_eth_rx_adapter.sv
// Receive-side adapter that turns an IP header/payload stream into a flat byte stream
// for the ROS2 core FIFO. The IPv4 header is re-serialised first, then the payload is trimmed or zero-padded to the IP length.
module ros2_eth_rx_adapter #(
    parameter bit         FILTER_UDP = 1'b1,
    parameter logic [7:0] UDP_PROTO  = 8'd17
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic        i_rx_hdr_valid,
    output logic        o_rx_hdr_ready,
    input  logic [5:0]  i_rx_ip_dscp,
    input  logic [1:0]  i_rx_ip_ecn,
    input  logic [15:0] i_rx_ip_length,
    input  logic [15:0] i_rx_ip_identification,
    input  logic [2:0]  i_rx_ip_flags,
    input  logic [12:0] i_rx_ip_fragment_offset,
    input  logic [7:0]  i_rx_ip_ttl,
    input  logic [7:0]  i_rx_ip_protocol,
    input  logic [15:0] i_rx_ip_header_checksum,
    input  logic [31:0] i_rx_ip_source_ip,
    input  logic [31:0] i_rx_ip_dest_ip,
    input  logic        i_rx_payload_tvalid,
    output logic        o_rx_payload_tready,
    input  logic [7:0]  i_rx_payload_tdata,
    input  logic        i_rx_payload_tlast,
    output logic [7:0]  o_dout_data,
    output logic        o_dout_wr_en,
    input  logic        i_dout_full_n,
    output logic [15:0] o_drop_count
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WR_HDR     = 3'd1;
    localparam logic [2:0] WR_PAYLOAD = 3'd2;
    localparam logic [2:0] PAD        = 3'd3;
    localparam logic [2:0] DROP       = 3'd4;

    logic [2:0]  state;
    logic [4:0]  hdr_idx;
    logic [15:0] counter;
    logic [15:0] len;

    logic [5:0]  hdr_dscp;
    logic [1:0]  hdr_ecn;
    logic [15:0] hdr_length;
    logic [15:0] hdr_id;
    logic [2:0]  hdr_flags;
    logic [12:0] hdr_frag;
    logic [7:0]  hdr_ttl;
    logic [7:0]  hdr_proto;
    logic [15:0] hdr_csum;
    logic [31:0] hdr_src;
    logic [31:0] hdr_dst;

    logic        active;
    logic        in_range;
    logic [15:0] cnt_inc;
    logic [15:0] cnt_next;
    logic [7:0]  hdr_byte;
    logic        hdr_take;
    logic        hdr_drop;
    logic        beat_take;

    // Ready outputs must also read zero while reset is held, hence the reset term here.
    assign active    = i_rst_n & i_enable;
    assign in_range  = counter < len;
    assign cnt_inc   = counter + 16'd1;
    assign cnt_next  = in_range ? cnt_inc : counter;
    assign hdr_take  = i_rx_hdr_valid & o_rx_hdr_ready;
    assign beat_take = i_rx_payload_tvalid & o_rx_payload_tready;
    assign hdr_drop  = (i_rx_ip_length < 16'd20) ||
                       (FILTER_UDP && (i_rx_ip_protocol != UDP_PROTO));

    always_comb begin
        hdr_byte = 8'h00;
        case (hdr_idx)
            5'd0:    hdr_byte = 8'h45;
            5'd1:    hdr_byte = {hdr_dscp, hdr_ecn};
            5'd2:    hdr_byte = hdr_length[15:8];
            5'd3:    hdr_byte = hdr_length[7:0];
            5'd4:    hdr_byte = hdr_id[15:8];
            5'd5:    hdr_byte = hdr_id[7:0];
            5'd6:    hdr_byte = {hdr_flags, hdr_frag[12:8]};
            5'd7:    hdr_byte = hdr_frag[7:0];
            5'd8:    hdr_byte = hdr_ttl;
            5'd9:    hdr_byte = hdr_proto;
            5'd10:   hdr_byte = hdr_csum[15:8];
            5'd11:   hdr_byte = hdr_csum[7:0];
            5'd12:   hdr_byte = hdr_src[31:24];
            5'd13:   hdr_byte = hdr_src[23:16];
            5'd14:   hdr_byte = hdr_src[15:8];
            5'd15:   hdr_byte = hdr_src[7:0];
            5'd16:   hdr_byte = hdr_dst[31:24];
            5'd17:   hdr_byte = hdr_dst[23:16];
            5'd18:   hdr_byte = hdr_dst[15:8];
            5'd19:   hdr_byte = hdr_dst[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    // Payload beats are only accepted when they can be written in the same cycle,
    // so tready and wr_en share the FIFO-not-full term while inside the IP length.
    always_comb begin
        o_rx_hdr_ready      = 1'b0;
        o_rx_payload_tready = 1'b0;
        o_dout_wr_en        = 1'b0;
        o_dout_data         = 8'h00;
        if (active) begin
            case (state)
                IDLE: o_rx_hdr_ready = 1'b1;
                WR_HDR: begin
                    o_dout_wr_en = i_dout_full_n;
                    o_dout_data  = hdr_byte;
                end
                WR_PAYLOAD: begin
                    if (in_range) begin
                        o_rx_payload_tready = i_dout_full_n;
                        o_dout_wr_en        = i_rx_payload_tvalid & i_dout_full_n;
                        o_dout_data         = i_rx_payload_tdata;
                    end else begin
                        o_rx_payload_tready = 1'b1;
                    end
                end
                PAD:     o_dout_wr_en = in_range & i_dout_full_n;
                DROP:    o_rx_payload_tready = 1'b1;
                default: o_dout_wr_en = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hdr_dscp   <= '0;
            hdr_ecn    <= '0;
            hdr_length <= '0;
            hdr_id     <= '0;
            hdr_flags  <= '0;
            hdr_frag   <= '0;
            hdr_ttl    <= '0;
            hdr_proto  <= '0;
            hdr_csum   <= '0;
            hdr_src    <= '0;
            hdr_dst    <= '0;
        end else if (hdr_take) begin
            hdr_dscp   <= i_rx_ip_dscp;
            hdr_ecn    <= i_rx_ip_ecn;
            hdr_length <= i_rx_ip_length;
            hdr_id     <= i_rx_ip_identification;
            hdr_flags  <= i_rx_ip_flags;
            hdr_frag   <= i_rx_ip_fragment_offset;
            hdr_ttl    <= i_rx_ip_ttl;
            hdr_proto  <= i_rx_ip_protocol;
            hdr_csum   <= i_rx_ip_header_checksum;
            hdr_src    <= i_rx_ip_source_ip;
            hdr_dst    <= i_rx_ip_dest_ip;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_drop_count <= '0;
        end else if (hdr_take && hdr_drop && (o_drop_count != 16'hFFFF)) begin
            o_drop_count <= o_drop_count + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            hdr_idx <= '0;
            counter <= '0;
            len     <= '0;
        end else if (!i_enable) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (hdr_take) begin
                        hdr_idx <= '0;
                        state   <= hdr_drop ? DROP : WR_HDR;
                    end
                end
                WR_HDR: begin
                    if (i_dout_full_n) begin
                        if (hdr_idx == 5'd19) begin
                            hdr_idx <= '0;
                            len     <= hdr_length - 16'd20;
                            counter <= '0;
                            state   <= WR_PAYLOAD;
                        end else begin
                            hdr_idx <= hdr_idx + 5'd1;
                        end
                    end
                end
                WR_PAYLOAD: begin
                    if (beat_take) begin
                        counter <= cnt_next;
                        if (i_rx_payload_tlast) begin
                            state <= (cnt_next >= len) ? IDLE : PAD;
                        end
                    end
                end
                PAD: begin
                    if (!in_range) begin
                        state <= IDLE;
                    end else if (i_dout_full_n) begin
                        counter <= cnt_inc;
                        if (cnt_inc == len) begin
                            state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (i_rx_payload_tvalid && i_rx_payload_tlast) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ros2_eth_rx_adapter.sv
// Bench for ros2_eth_rx_adapter: directed IP packets plus randomized ones, checked against
// a packet-level model that builds the expected FIFO byte stream from the header fields and payload.
module tb_ros2_eth_rx_adapter;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [5:0]  ip_dscp;
    logic [1:0]  ip_ecn;
    logic [15:0] ip_length;
    logic [15:0] ip_id;
    logic [2:0]  ip_flags;
    logic [12:0] ip_frag;
    logic [7:0]  ip_ttl;
    logic [7:0]  ip_proto;
    logic [15:0] ip_csum;
    logic [31:0] ip_src;
    logic [31:0] ip_dst;
    logic        tvalid;
    logic        tready;
    logic [7:0]  tdata;
    logic        tlast;
    logic [7:0]  dout_data;
    logic        dout_wr_en;
    logic        full_n;
    logic [15:0] drop_count;

    int          vectors = 0;
    int          miscompares = 0;
    int          stall_viol = 0;
    int          full_mode = 0;
    logic [15:0] exp_drops = 16'd0;
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  pay_q[$];

    ros2_eth_rx_adapter #(
        .FILTER_UDP(1'b1),
        .UDP_PROTO (8'd17)
    ) dut (
        .i_clk                  (clk),
        .i_rst_n                (rst_n),
        .i_enable               (enable),
        .i_rx_hdr_valid         (hdr_valid),
        .o_rx_hdr_ready         (hdr_ready),
        .i_rx_ip_dscp           (ip_dscp),
        .i_rx_ip_ecn            (ip_ecn),
        .i_rx_ip_length         (ip_length),
        .i_rx_ip_identification (ip_id),
        .i_rx_ip_flags          (ip_flags),
        .i_rx_ip_fragment_offset(ip_frag),
        .i_rx_ip_ttl            (ip_ttl),
        .i_rx_ip_protocol       (ip_proto),
        .i_rx_ip_header_checksum(ip_csum),
        .i_rx_ip_source_ip      (ip_src),
        .i_rx_ip_dest_ip        (ip_dst),
        .i_rx_payload_tvalid    (tvalid),
        .o_rx_payload_tready    (tready),
        .i_rx_payload_tdata     (tdata),
        .i_rx_payload_tlast     (tlast),
        .o_dout_data            (dout_data),
        .o_dout_wr_en           (dout_wr_en),
        .i_dout_full_n          (full_n),
        .o_drop_count           (drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIFO back-pressure: 0 = never full, 1 = alternate every cycle, 2 = random.
    initial begin
        full_n = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (full_mode)
                0:       full_n = 1'b1;
                1:       full_n = ~full_n;
                default: full_n = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (dout_wr_en === 1'b1) begin
                got_q.push_back(dout_data);
                if (full_n !== 1'b1) stall_viol++;
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: observed simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic setHeader(input logic [15:0] length, input logic [7:0] proto);
        ip_dscp   = 6'($urandom);
        ip_ecn    = 2'($urandom);
        ip_length = length;
        ip_id     = 16'($urandom);
        ip_flags  = 3'($urandom);
        ip_frag   = 13'($urandom);
        ip_ttl    = 8'($urandom);
        ip_proto  = proto;
        ip_csum   = 16'($urandom);
        ip_src    = $urandom;
        ip_dst    = $urandom;
    endtask

    // Reference model: a wire-order IPv4 header followed by exactly (length-20) bytes,
    // taken from the payload and zero-filled if the payload ran short.
    task automatic buildExpected();
        logic [159:0] hv;
        int           plen;
        exp_q.delete();
        if (ip_length < 16'd20 || ip_proto != 8'd17) begin
            if (exp_drops != 16'hFFFF) exp_drops++;
            return;
        end
        hv = {8'h45, ip_dscp, ip_ecn, ip_length, ip_id, ip_flags, ip_frag,
              ip_ttl, ip_proto, ip_csum, ip_src, ip_dst};
        for (int k = 0; k < 20; k++) exp_q.push_back(hv[159-8*k -: 8]);
        plen = int'(ip_length) - 20;
        for (int i = 0; i < plen; i++) exp_q.push_back((i < pay_q.size()) ? pay_q[i] : 8'h00);
    endtask

    task automatic sendHeader(output bit ok);
        int waited = 0;
        bit seen = 1'b0;
        hdr_valid = 1'b1;
        while (!seen && waited < 200) begin
            @(negedge clk);
            seen = hdr_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        hdr_valid = 1'b0;
        ok = seen;
    endtask

    task automatic sendPayload(output bit ok);
        bit taken;
        int waited;
        ok = 1'b1;
        for (int i = 0; i < pay_q.size() && ok; i++) begin
            if (full_mode == 2 && $urandom_range(0, 3) == 0) begin
                tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            tvalid = 1'b1;
            tdata  = pay_q[i];
            tlast  = (i == pay_q.size() - 1);
            taken  = 1'b0;
            waited = 0;
            while (!taken && waited < 500) begin
                @(negedge clk);
                taken = tready;
                @(posedge clk);
                #1;
                waited++;
            end
            ok = taken;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic waitIdle(output bit ok);
        int waited = 0;
        bit seen = 1'b0;
        while (!seen && waited < 500) begin
            @(negedge clk);
            seen = hdr_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        ok = seen;
    endtask

    task automatic checkPacket(input string tag);
        int n;
        checkOutput({tag, "_nbytes"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) checkOutput($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
        checkOutput({tag, "_drops"}, drop_count, exp_drops);
        checkOutput({tag, "_wr_while_full"}, stall_viol, 0);
    endtask

    task automatic applyStimulus(input string tag);
        bit ok;
        got_q.delete();
        stall_viol = 0;
        buildExpected();
        sendHeader(ok);
        checkOutput({tag, "_hdr_accept"}, ok, 1);
        sendPayload(ok);
        checkOutput({tag, "_payload_accept"}, ok, 1);
        waitIdle(ok);
        checkOutput({tag, "_idle"}, ok, 1);
        checkPacket(tag);
    endtask

    initial begin
        int snapshot;
        int waited;
        int n;
        logic [15:0] rlen;
        logic [7:0]  rproto;

        rst_n     = 1'b0;
        enable    = 1'b1;
        hdr_valid = 1'b1;
        tvalid    = 1'b1;
        tdata     = 8'h00;
        tlast     = 1'b0;
        setHeader(16'd24, 8'd17);
        #2;
        checkOutput("rst_hdr_ready", hdr_ready, 0);
        checkOutput("rst_tready", tready, 0);
        checkOutput("rst_wr_en", dout_wr_en, 0);
        checkOutput("rst_data", dout_data, 0);
        checkOutput("rst_drops", drop_count, 0);
        hdr_valid = 1'b0;
        tvalid    = 1'b0;
        enable    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("disabled_hdr_ready", hdr_ready, 0);
        @(posedge clk);
        #1;
        enable = 1'b1;
        @(negedge clk);
        checkOutput("enabled_hdr_ready", hdr_ready, 1);
        @(posedge clk);
        #1;

        $display("[TB] UDP packet, FIFO never full");
        full_mode = 0;
        setHeader(16'd24, 8'd17);
        ip_src = 32'h0A000001;
        ip_dst = 32'h0A000002;
        pay_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        applyStimulus("udp24");

        $display("[TB] Same packet, FIFO full every other cycle");
        full_mode = 1;
        applyStimulus("udp24_toggle");
        full_mode = 0;

        $display("[TB] Short payload padded with zeros");
        setHeader(16'd24, 8'd17);
        pay_q = '{8'hAA, 8'hBB};
        applyStimulus("pad");

        $display("[TB] Long payload truncated");
        setHeader(16'd22, 8'd17);
        pay_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        applyStimulus("trunc");

        $display("[TB] Non-UDP and undersized packets dropped");
        setHeader(16'd24, 8'd6);
        pay_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        applyStimulus("tcp_drop");
        setHeader(16'd19, 8'd17);
        pay_q = '{8'hD1, 8'hD2};
        applyStimulus("short_drop");

        $display("[TB] Randomized packets with random back-pressure");
        full_mode = 2;
        for (int p = 0; p < 30; p++) begin
            rlen   = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 19)) : 16'($urandom_range(20, 60));
            rproto = ($urandom_range(0, 4) == 0) ? 8'd6 : 8'd17;
            n      = $urandom_range(1, 45);
            pay_q.delete();
            for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
            setHeader(rlen, rproto);
            applyStimulus($sformatf("rnd%0d", p));
        end
        full_mode = 0;

        $display("[TB] Enable dropped in the middle of the payload");
        setHeader(16'd40, 8'd17);
        begin
            bit ok;
            got_q.delete();
            sendHeader(ok);
            checkOutput("en_hdr_accept", ok, 1);
        end
        tvalid = 1'b1;
        tdata  = 8'h5A;
        tlast  = 1'b0;
        waited = 0;
        while (got_q.size() < 23 && waited < 200) begin
            @(posedge clk);
            waited++;
        end
        checkOutput("en_reached_payload", (got_q.size() >= 23), 1);
        #1;
        enable   = 1'b0;
        snapshot = got_q.size();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("en_off_wr_en%0d", c), dout_wr_en, 0);
            checkOutput($sformatf("en_off_tready%0d", c), tready, 0);
            checkOutput($sformatf("en_off_hdr_ready%0d", c), hdr_ready, 0);
        end
        @(posedge clk);
        #1;
        checkOutput("en_off_no_writes", got_q.size(), snapshot);
        checkOutput("en_off_drops_held", drop_count, exp_drops);
        tvalid = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        checkOutput("en_back_idle", hdr_ready, 1);
        @(posedge clk);
        #1;

        $display("[TB] Asynchronous reset in the middle of the header");
        setHeader(16'd30, 8'd17);
        begin
            bit ok;
            got_q.delete();
            sendHeader(ok);
            checkOutput("rst2_hdr_accept", ok, 1);
        end
        waited = 0;
        while (got_q.size() < 5 && waited < 200) begin
            @(posedge clk);
            waited++;
        end
        checkOutput("rst2_reached_hdr", (got_q.size() >= 5), 1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("rst2_wr_en", dout_wr_en, 0);
        checkOutput("rst2_data", dout_data, 0);
        checkOutput("rst2_hdr_ready", hdr_ready, 0);
        checkOutput("rst2_tready", tready, 0);
        checkOutput("rst2_drops", drop_count, 0);
        exp_drops = 16'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        setHeader(16'd26, 8'd17);
        pay_q = '{8'h61, 8'h62, 8'h63};
        applyStimulus("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ros2_eth_rx_adapter.md
ROS2_ETH_RX_ADAPTER -- requirements
Module: ros2_eth_rx_adapter

Interface
REQ-001 Parameter: FILTER_UDP, default 1, meaning 1 = drop packets whose protocol is not 17 and 0 = pass all protocols.
REQ-002 Parameter: UDP_PROTO, default 8'd17, meaning protocol value accepted when FILTER_UDP=1.
REQ-003 Ports, one per line (name, direction, width, meaning):
  i_clk  in  1  clock
  i_rst_n  in  1  reset, asynchronous, active-low
  i_enable  in  1  block enable; low = idle/flush
  i_rx_hdr_valid  in  1  IP header valid
  o_rx_hdr_ready  out  1  IP header accept
  i_rx_ip_dscp  in  6  DSCP
  i_rx_ip_ecn  in  2  ECN
  i_rx_ip_length  in  16  IP total length
  i_rx_ip_identification  in  16  ID
  i_rx_ip_flags  in  3  flags
  i_rx_ip_fragment_offset  in  13  fragment offset
  i_rx_ip_ttl  in  8  TTL
  i_rx_ip_protocol  in  8  protocol
  i_rx_ip_header_checksum  in  16  checksum
  i_rx_ip_source_ip  in  32  source address
  i_rx_ip_dest_ip  in  32  destination address
  i_rx_payload_tvalid  in  1  payload byte valid
  o_rx_payload_tready  out  1  payload byte accept
  i_rx_payload_tdata  in  8  payload byte
  i_rx_payload_tlast  in  1  last payload byte
  o_dout_data  out  8  byte to ROS2 core FIFO
  o_dout_wr_en  out  1  FIFO write strobe
  i_dout_full_n  in  1  FIFO not full
  o_drop_count  out  16  dropped-packet count, saturating

Function
REQ-004 The FSM SHALL have states IDLE, WR_HDR, WR_PAYLOAD, PAD and DROP.
REQ-005 o_rx_hdr_ready SHALL be high only in IDLE with i_enable high; a header is captured into registers on the cycle valid&ready.
REQ-006 On capture, the block SHALL go to DROP (increment o_drop_count, saturating at 16'hFFFF) if length<20, or if FILTER_UDP=1 and protocol!=UDP_PROTO; otherwise it SHALL go to WR_HDR with byte offset 0.
REQ-007 WR_HDR SHALL emit 20 bytes in IPv4 wire order: 8'h45, {dscp,ecn}, length[15:8], length[7:0], id MSB/LSB, {flags,frag_off} MSB/LSB, ttl, protocol, checksum MSB/LSB, source IP MSB-first, then dest IP MSB-first.
REQ-008 A byte SHALL be written (o_dout_wr_en=1) only in a cycle with i_dout_full_n=1; the offset advances on each write, and after byte 19 the FSM SHALL move to WR_PAYLOAD with len=length-20 and counter=0.
REQ-009 In WR_PAYLOAD with counter<len: tready=i_dout_full_n; o_dout_data=tdata; wr_en=tvalid&full_n; counter increments per write.
REQ-010 In WR_PAYLOAD with counter>=len (including len=0): tready=1, no writes; excess bytes are discarded.
REQ-011 A tlast beat accepted in WR_PAYLOAD SHALL go to IDLE if counter (after that beat) >= len, else to PAD.
REQ-012 PAD SHALL write 8'h00 per full_n cycle until counter==len, then go to IDLE; tready=0 in PAD.
REQ-013 DROP SHALL assert tready=1 with no writes and go to IDLE on an accepted tlast.
REQ-014 In IDLE and WR_HDR, o_rx_payload_tready SHALL be 0.
REQ-015 counter and len SHALL be 16-bit; the counter<len compare is unsigned.
REQ-016 i_enable low SHALL force IDLE synchronously, abandon the current packet with no further writes, and deassert both ready outputs; o_drop_count holds its value.

Reset
REQ-017 While i_rst_n is low: state=IDLE, all outputs 0 (o_dout_data=0, o_dout_wr_en=0, both readies=0, o_drop_count=0), and all header registers, counter and len are 0.
REQ-018 After reset release, the first header is accepted no earlier than the first i_clk edge with i_enable high.

Verification
REQ-019 The bench SHALL cover these scenarios:
  - UDP hdr length=24, src 0A000001, dst 0A000002, payload 11 22 33 44 (tlast on 44), full_n=1 -> 24 writes: 45 .. 00 18 .. 0A 00 00 01 0A 00 00 02 11 22 33 44, then IDLE.
  - Same packet with full_n toggling 1/0 every cycle -> identical 24-byte sequence, no byte lost or duplicated.
  - length=24, payload AA BB with tlast on BB -> header + AA BB 00 00.
  - length=22, payload 5 bytes -> header + first 2 bytes; remaining 3 bytes accepted and discarded.
  - protocol=6 with FILTER_UDP=1 -> zero writes, payload consumed through tlast, o_drop_count 0->1; length=19 -> also dropped.
  - i_enable cleared mid-payload -> writes stop next cycle; async reset mid-header -> all outputs 0 immediately.
